spi_sampler: RTL

Triggered serial-ADC reader that consumes the `start` square wave from the sample-rate generator. Every rising edge of `start` launches one SPI read (mode 0, MSB first) of a DATA_W-bit sample. The block presents the sample on `data_out` with a one-cycle `data_valid` strobe for the downstream processing/display logic. Rate control stays entirely in the generator; this block only reacts to edges.

---
 rtl/spi_sampler_pkg.sv | 16 +
 rtl/spi_sampler_clkdiv.sv | 31 +++
 rtl/spi_sampler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/spi_sampler_pkg.sv
// Shared types and default parameters for the triggered SPI ADC sampler.
package spi_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam int CLK_DIV_DEF  = 50;
  localparam int DATA_W_DEF   = 16;
  localparam int CS_SETUP_DEF = 4;
  localparam int OVR_CNT_W    = 8;

endpackage

// File: rtl/spi_sampler_clkdiv.sv
// SCLK half-period divider: one-cycle tick every CLK_DIV cycles while enabled.
module spi_sampler_clkdiv
  import spi_sampler_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  // Held at zero while disabled so every enable starts a full half-period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/spi_sampler.sv
// Edge-triggered SPI mode-0 ADC reader. Optional SPI_SAMPLER_OVR_CNT_EN adds a
// saturating count of dropped triggers on port ovr_cnt.
module spi_sampler
  import spi_sampler_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CS_SETUP = CS_SETUP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              ovr,
`ifdef SPI_SAMPLER_OVR_CNT_EN
  output logic [OVR_CNT_W-1:0] ovr_cnt,
`endif
  output spi_state_t        state
);

  localparam int CW = $clog2(CS_SETUP + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CS_TERM  = CW'(CS_SETUP - 1);
  localparam logic [BW-1:0] BIT_TERM = BW'(DATA_W - 1);

  logic              start_q;
  logic              trig;
  logic              tick;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] sr;

  assign trig = start && !start_q;
  assign busy = (state != IDLE);
  assign cs_n = (state == IDLE);
  // A trigger is only ever dropped, never queued: the rate generator owns pacing.
  assign ovr  = !rst && trig && busy;

  spi_sampler_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      sclk       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      cnt        <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
    end else begin
      start_q    <= start;
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            state <= SETUP;
            cnt   <= '0;
          end
        end
        SETUP: begin
          if (cnt == CS_TERM) begin
            state   <= SHIFT;
            cnt     <= '0;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // Rising SCLK edge samples miso; falling edge closes the bit.
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
              sr   <= DATA_W'({sr, miso});
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_TERM) begin
                state <= HOLD;
                cnt   <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (cnt == CS_TERM) begin
            state      <= IDLE;
            data_out   <= sr;
            data_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SAMPLER_OVR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt <= '0;
    end else if (ovr && (ovr_cnt != {OVR_CNT_W{1'b1}})) begin
      ovr_cnt <= ovr_cnt + OVR_CNT_W'(1);
    end
  end
`endif

endmodule
